// File: rtl/ls_usb_tx_framer_pkg.sv
// ls_usb_tx_framer_pkg: PID codes, CRC16 constants and framer state encoding
package ls_usb_tx_framer_pkg;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK = 4'h2;
    localparam logic [3:0] PID_NAK = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'hB001;
    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRCL, ST_CRCH, ST_DRAIN
    } state_t;
    function automatic logic is_data_pid(input logic [3:0] p);
        return p == PID_DATA0 || p == PID_DATA1;
    endfunction
endpackage

// File: rtl/ls_usb_crc16_byte.sv
// ls_usb_crc16_byte: one byte of reflected CRC16 (LSB first), purely combinational
module ls_usb_crc16_byte
    import ls_usb_tx_framer_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);
    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < 8; i++)
            crc_o = (crc_o[0] ^ byte_i[i]) ? ((crc_o >> 1) ^ CRC16_POLY) : (crc_o >> 1);
    end
endmodule

// File: rtl/ls_usb_tx_framer.sv
// ls_usb_tx_framer: frames SYNC, PID, payload and CRC16 bytes for the low-speed
// USB bit-level transmitter, advancing one byte per show_next.
module ls_usb_tx_framer
    import ls_usb_tx_framer_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_PATTERN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       tx_req,
    input  logic [3:0] tx_pid,
    input  logic [3:0] tx_len,
    input  logic       show_next,
    input  logic       bus_enable,
    output logic [7:0] sbyte,
    output logic       start_pkt,
    output logic       last_pkt_byte,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [3:0] MAX = 4'(MAX_LEN);
    state_t state_q, state_d;
    logic [7:0] buf_q [16];
    logic [7:0] sbyte_q, sbyte_d;
    logic [3:0] pid_q, pid_d, len_q, len_d, idx_q, idx_d;
    logic [15:0] crc_q, crc_d, crc_nx;
    logic data_q, data_d, start_q, start_d, last_q, last_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic bad_req, last_data;
    assign bad_req = is_data_pid(tx_pid) && tx_len > MAX;
    assign last_data = idx_q == len_q - 4'd1;
    ls_usb_crc16_byte u_crc (.crc_i(crc_q), .byte_i(buf_q[idx_q]), .crc_o(crc_nx));
    // Buffer has no reset; slots at or beyond MAX_LEN are never written
    always_ff @(posedge clk)
        if (wr_en && state_q == ST_IDLE && wr_addr < MAX) buf_q[wr_addr] <= wr_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sbyte_q <= 8'h00;
            pid_q <= 4'h0;
            len_q <= 4'h0;
            idx_q <= 4'h0;
            crc_q <= CRC16_INIT;
            data_q <= 1'b0;
            start_q <= 1'b0;
            last_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sbyte_q <= sbyte_d;
            pid_q <= pid_d;
            len_q <= len_d;
            idx_q <= idx_d;
            crc_q <= crc_d;
            data_q <= data_d;
            start_q <= start_d;
            last_q <= last_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tx_req && !bad_req) state_d = ST_SYNC;
            ST_SYNC:  if (show_next) state_d = ST_PID;
            ST_PID:   if (show_next) state_d = !data_q ? ST_DRAIN : len_q != 4'd0 ? ST_DATA : ST_CRCL;
            ST_DATA:  if (show_next && last_data) state_d = ST_CRCL;
            ST_CRCL:  if (show_next) state_d = ST_CRCH;
            ST_CRCH:  if (show_next) state_d = ST_DRAIN;
            ST_DRAIN: if (!bus_enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        sbyte_d = sbyte_q;
        pid_d = pid_q;
        len_d = len_q;
        idx_d = idx_q;
        crc_d = crc_q;
        data_d = data_q;
        start_d = 1'b0;
        last_d = last_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            ST_IDLE: if (tx_req) begin
                if (bad_req) err_d = 1'b1;
                else begin
                    pid_d = tx_pid;
                    len_d = tx_len;
                    data_d = is_data_pid(tx_pid);
                    idx_d = 4'd0;
                    crc_d = CRC16_INIT;
                    sbyte_d = SYNC_BYTE;
                    start_d = 1'b1;
                    busy_d = 1'b1;
                    last_d = 1'b0;
                end
            end
            ST_SYNC: if (show_next) begin
                sbyte_d = {~pid_q, pid_q};
                last_d = !data_q;
            end
            ST_PID: if (show_next) begin
                last_d = 1'b0;
                sbyte_d = !data_q ? sbyte_q : len_q != 4'd0 ? buf_q[0] : ~crc_q[7:0];
            end
            // CRC absorbs the byte being retired; the low CRC byte must use the updated value
            ST_DATA: if (show_next) begin
                crc_d = crc_nx;
                idx_d = last_data ? idx_q : idx_q + 4'd1;
                sbyte_d = last_data ? ~crc_nx[7:0] : buf_q[idx_q + 4'd1];
            end
            ST_CRCL: if (show_next) begin
                sbyte_d = ~crc_q[15:8];
                last_d = 1'b1;
            end
            ST_CRCH: if (show_next) last_d = 1'b0;
            ST_DRAIN: if (!bus_enable) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end
    assign sbyte = sbyte_q;
    assign start_pkt = start_q;
    assign last_pkt_byte = last_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
endmodule

// File: tb/tb_ls_usb_tx_framer.sv
// tb_ls_usb_tx_framer: directed checks of the framer at MAX_LEN=8 and MAX_LEN=9
module tb_ls_usb_tx_framer;
    logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, tx_req = 1'b0, show_next = 1'b0, bus_enable = 1'b0;
    logic [3:0] wr_addr = 4'h0, tx_pid = 4'h0, tx_len = 4'h0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] sbyte8, sbyte9;
    logic start8, start9, last8, last9, busy8, busy9, done8, done9, err8, err9;
    logic sel = 1'b0;
    logic [7:0] sb;
    logic st, lb, bz, dn, er;
    logic [7:0] exp_b [16];
    int n_chk = 0, n_err = 0;
    always #5 clk = ~clk;
    ls_usb_tx_framer #(.MAX_LEN(8)) u8 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tx_req(tx_req), .tx_pid(tx_pid), .tx_len(tx_len), .show_next(show_next),
        .bus_enable(bus_enable), .sbyte(sbyte8), .start_pkt(start8), .last_pkt_byte(last8),
        .busy(busy8), .done(done8), .err(err8));
    ls_usb_tx_framer #(.MAX_LEN(9)) u9 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tx_req(tx_req), .tx_pid(tx_pid), .tx_len(tx_len), .show_next(show_next),
        .bus_enable(bus_enable), .sbyte(sbyte9), .start_pkt(start9), .last_pkt_byte(last9),
        .busy(busy9), .done(done9), .err(err9));
    assign sb = sel ? sbyte9 : sbyte8;
    assign st = sel ? start9 : start8;
    assign lb = sel ? last9 : last8;
    assign bz = sel ? busy9 : busy8;
    assign dn = sel ? done9 : done8;
    assign er = sel ? err9 : err8;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic show();
        show_next = 1'b1;
        tick();
        show_next = 1'b0;
    endtask
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask
    // Sends one packet and walks it byte by byte against exp_b[0..n-1]
    task automatic pkt(input logic [3:0] pid, input logic [3:0] len, input int n, input bit poke);
        tx_pid = pid;
        tx_len = len;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        bus_enable = 1'b1;
        check("start_pulse", {15'd0, st}, 16'd1);
        check("busy_on", {15'd0, bz}, 16'd1);
        check("sync_byte", {8'd0, sb}, {8'd0, exp_b[0]});
        check("sync_last", {15'd0, lb}, 16'd0);
        if (poke) begin
            tx_req = 1'b1;
            tx_pid = 4'h3;
            tx_len = 4'd9;
            wr_en = 1'b1;
            wr_addr = 4'd8;
            wr_data = 8'hEE;
        end
        tick();
        tx_req = 1'b0;
        wr_en = 1'b0;
        check("start_once", {15'd0, st}, 16'd0);
        check("sync_hold", {8'd0, sb}, {8'd0, exp_b[0]});
        for (int k = 1; k < n; k++) begin
            show();
            check($sformatf("byte%0d", k), {8'd0, sb}, {8'd0, exp_b[k]});
            check($sformatf("last%0d", k), {15'd0, lb}, {15'd0, k == n - 1});
            tick();
            check($sformatf("hold%0d", k), {8'd0, sb}, {8'd0, exp_b[k]});
        end
        show();
        check("drain_last", {15'd0, lb}, 16'd0);
        check("drain_busy", {15'd0, bz}, 16'd1);
        tick();
        tick();
        check("drain_wait", {15'd0, dn}, 16'd0);
        bus_enable = 1'b0;
        tick();
        check("done_pulse", {15'd0, dn}, 16'd1);
        check("busy_off", {15'd0, bz}, 16'd0);
        tick();
        check("done_once", {15'd0, dn}, 16'd0);
    endtask
    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_sbyte", {8'd0, sbyte8}, 16'h0000);
        check("rst_flags", {10'd0, start8, last8, busy8, done8, err8, 1'b0}, 16'h0000);
        tick();
        exp_b[0] = 8'h80; exp_b[1] = 8'hD2;
        pkt(4'h2, 4'd0, 2, 1'b0);
        exp_b[1] = 8'hC3; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
        pkt(4'h3, 4'd0, 4, 1'b0);
        for (int i = 0; i < 9; i++) wr(4'(i), 8'h31 + 8'(i));
        sel = 1'b1;
        exp_b[1] = 8'h4B;
        for (int i = 0; i < 9; i++) exp_b[2 + i] = 8'h31 + 8'(i);
        exp_b[11] = 8'hC8; exp_b[12] = 8'hB4;
        pkt(4'hB, 4'd9, 13, 1'b1);
        show();
        tick();
        check("idle_show_sbyte", {8'd0, sb}, 16'h00B4);
        check("idle_show_flags", {12'd0, st, lb, bz, dn}, 16'h0000);
        sel = 1'b0;
        tx_pid = 4'h3;
        tx_len = 4'd9;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        check("err_pulse", {15'd0, er}, 16'd1);
        check("err_nostart", {14'd0, st, bz}, 16'd0);
        tick();
        check("err_once", {15'd0, er}, 16'd0);
        check("err_idle", {14'd0, st, bz}, 16'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tx_pid = 4'h3;
        tx_len = 4'd2;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        bus_enable = 1'b1;
        show();
        show();
        check("mid_data_byte", {8'd0, sb}, 16'h0031);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_enable = 1'b0;
        check("abort_sbyte", {8'd0, sb}, 16'h0000);
        check("abort_flags", {11'd0, st, lb, bz, dn, er}, 16'h0000);
        tick();
        check("abort_nodone", {15'd0, dn}, 16'd0);
        exp_b[1] = 8'hC3; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
        pkt(4'h3, 4'd0, 4, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ls_usb_tx_framer.md
Name: ls_usb_tx_framer

Overview:
- Packet framer directly upstream of the low-speed USB bit-level transmitter (NRZI, bit stuffing, EOP).
- Takes a PID and up to MAX_LEN payload bytes from a local buffer.
- Emits the byte stream SYNC, PID, [DATA..., CRC16 lo, CRC16 hi] on the transmitter's sbyte/start_pkt/last_pkt_byte interface, paced by its show_next pulses.
- Reports busy/done to the endpoint logic.

Parameters:
MAX_LEN, 8, payload buffer depth in bytes (1..15)
SYNC_BYTE, 8'h80, SYNC pattern, LSB first

Ports:
clk  in  1  system clock (same 5 MHz domain as transmitter)
reset  in  1  synchronous, active-high reset
wr_en  in  1  payload buffer write strobe
wr_addr  in  4  payload byte index
wr_data  in  8  payload byte
tx_req  in  1  one-cycle request to send a packet
tx_pid  in  4  PID nibble; byte sent is {~tx_pid, tx_pid}
tx_len  in  4  payload length 0..MAX_LEN (ignored for non-DATA PIDs)
show_next  in  1  transmitter has latched sbyte; present the next byte
bus_enable  in  1  transmitter driving bus (falls after EOP)
sbyte  out  8  byte presented to transmitter
start_pkt  out  1  one-cycle packet start pulse
last_pkt_byte  out  1  high while final byte is presented
busy  out  1  packet in progress
done  out  1  one-cycle pulse at packet completion
err  out  1  one-cycle pulse: request rejected (tx_len > MAX_LEN)

Behaviour:
- Reset (synchronous, clk edge): state IDLE; sbyte=8'h00, start_pkt=0, last_pkt_byte=0, busy=0, done=0, err=0; CRC reg=16'hFFFF. Buffer contents are not reset.
- Buffer writes are accepted only in IDLE, including the tx_req cycle. Writes with wr_addr >= MAX_LEN are dropped.
- Data PIDs are 4'h3 (DATA0) and 4'hB (DATA1): payload plus CRC16. All other PIDs are sent as a single-byte packet: SYNC, PID.
- In IDLE, tx_req with a data PID and tx_len > MAX_LEN: err pulses next cycle, state stays IDLE.
- Otherwise, in IDLE, tx_req is accepted (cycle T):
  - pid, len and data flag are latched.
  - At T+1: busy=1, start_pkt=1 for exactly one cycle, sbyte=SYNC_BYTE; state SYNC.
- tx_req while busy is ignored.
- All outputs are registered. A show_next seen in state S advances the state, and the new sbyte/last_pkt_byte appear on the next cycle.
- show_next is ignored in IDLE and DRAIN.
- State transitions on show_next:
  - SYNC -> PID: sbyte={~pid,pid}; last_pkt_byte=1 if non-data.
  - PID -> DRAIN if non-data; else DATA (sbyte=buf[0]) if len>0, else CRCL.
  - DATA: index increments on each show_next; after buf[len-1] -> CRCL.
  - CRCL: sbyte=~crc[7:0].
  - CRCL -> CRCH: sbyte=~crc[15:8], last_pkt_byte=1.
  - CRCH -> DRAIN.
- CRC16:
  - Reflected poly 16'hA001, init 16'hFFFF, LSB first.
  - Updated with each payload byte in the cycle its show_next is seen.
  - Transmitted complemented, low byte first.
  - Re-initialised to 16'hFFFF on accept.
- DRAIN:
  - last_pkt_byte cleared.
  - Wait for bus_enable=0.
  - Then done=1 for one cycle, busy=0, IDLE.
- Reset mid-packet aborts immediately, with no done. The transmitter has its own reset.
- tx_len=0 DATA packet gives CRC bytes 8'h00, 8'h00.
- The index counter is 4 bits and never wraps, because len <= MAX_LEN <= 15.

Decomposition:
- Shared package: PID constants (DATA0=4'h3, DATA1=4'hB, ACK=4'h2, NAK=4'hA, STALL=4'hE), SYNC_BYTE, CRC16 poly/init/residue, state encoding.
- Sub-module ls_usb_crc16_byte: combinational 8-iteration reflected CRC16 step, crc_in[15:0] + byte -> crc_out[15:0].

Test Plan:
- ACK (tx_pid=4'h2): start_pkt one pulse at T+1; bytes on successive show_next = 80, D2. last_pkt_byte high only with D2. done after bus_enable falls.
- DATA0, tx_len=0: bytes 80, C3, 00, 00. last_pkt_byte only with final 00.
- MAX_LEN=9 override, DATA1, payload 0x31..0x39: bytes 80, 4B, 31..39, C8, B4. CRC check value 0xB4C8.
- DATA0 with tx_len=9 at MAX_LEN=8: err pulse. No start_pkt, busy stays 0.
- tx_req and wr_en while busy: no restart, buffer unchanged. Spurious show_next in IDLE: no output change.
- Reset asserted during DATA state: next cycle all outputs reset, no done. New tx_req then sends a complete packet correctly.
